// File: rtl/fft_band_detect.sv
// Per-frame band power detector: bins one FFT frame of power samples into contiguous bands,
// then applies debounced on/off hysteresis per band and reports the loudest band.
module fft_band_detect #(
   parameter int unsigned FFT_LEN     = 1024,
   parameter int unsigned BIN_W       = 10,
   parameter int unsigned PWR_W       = 32,
   parameter int unsigned NUM_BANDS   = 25,
   parameter int unsigned FIRST_BIN   = 8,
   parameter int unsigned BAND_WIDTH  = 4,
   parameter int unsigned HOLD_FRAMES = 2,
   localparam int unsigned ACC_W      = PWR_W + $clog2(BAND_WIDTH),
   localparam int unsigned BAND_W     = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic                 i_sop,
   input  logic [BIN_W-1:0]     i_bin,
   input  logic [PWR_W-1:0]     i_power,
   input  logic [ACC_W-1:0]     i_thr_on,
   input  logic [ACC_W-1:0]     i_thr_off,
   output logic [NUM_BANDS-1:0] o_note,
   output logic [ACC_W-1:0]     o_power,
   output logic [BAND_W-1:0]    o_peak_band,
   output logic                 o_frame_done,
   output logic                 o_busy
);

   localparam int unsigned CNT_W      = $clog2(HOLD_FRAMES + 1);
   localparam int unsigned BAND_SHIFT = $clog2(BAND_WIDTH);
   localparam int unsigned BAND_END   = FIRST_BIN + NUM_BANDS * BAND_WIDTH;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_EVAL  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [BIN_W-1:0]  END_BIN   = BIN_W'(FFT_LEN - 1);
   localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);
   localparam logic [CNT_W-1:0]  HOLD_CNT  = CNT_W'(HOLD_FRAMES);

   logic [1:0]           state_q, state_d;
   logic [ACC_W-1:0]     acc_q [NUM_BANDS];
   logic [ACC_W-1:0]     acc_d [NUM_BANDS];
   logic [CNT_W-1:0]     on_cnt_q [NUM_BANDS];
   logic [CNT_W-1:0]     off_cnt_q [NUM_BANDS];
   logic [NUM_BANDS-1:0] note_work_q, note_q;
   logic [BAND_W-1:0]    idx_q;
   logic [ACC_W-1:0]     max_q, power_q;
   logic [BAND_W-1:0]    max_band_q, peak_q;

   logic                 start, accept, in_range, frame_end;
   logic [31:0]          bin_ext, rel;
   logic [BAND_W-1:0]    hit_band;
   logic [ACC_W-1:0]     base, acc_sat;
   logic [ACC_W:0]       sum;

   assign bin_ext   = 32'(i_bin);
   assign rel       = bin_ext - FIRST_BIN;
   assign hit_band  = BAND_W'(rel >> BAND_SHIFT);
   assign in_range  = (bin_ext >= FIRST_BIN) && (bin_ext < BAND_END);
   assign start     = i_valid && i_sop && (state_q == ST_IDLE || state_q == ST_ACCUM);
   assign accept    = i_valid && ((state_q == ST_IDLE && i_sop) || state_q == ST_ACCUM);
   assign frame_end = accept && (i_bin == END_BIN);

   // A sop sample starts from an empty band, even when it restarts an open frame.
   always_comb begin
      base    = start ? '0 : acc_q[hit_band];
      sum     = {1'b0, base} + {{(ACC_W + 1 - PWR_W){1'b0}}, i_power};
      acc_sat = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
   end

   always_comb begin
      for (int unsigned k = 0; k < NUM_BANDS; k++) begin
         acc_d[k] = acc_q[k];
         if (state_q == ST_DONE || start) acc_d[k] = '0;
         if (accept && in_range && hit_band == BAND_W'(k)) acc_d[k] = acc_sat;
      end
   end

   logic [ACC_W-1:0]     p;
   logic                 cur_bit, new_bit, last, take;
   logic [CNT_W-1:0]     on_n, off_n;
   logic [NUM_BANDS-1:0] note_final;
   logic [ACC_W-1:0]     max_nxt;
   logic [BAND_W-1:0]    band_nxt;

   always_comb begin
      p       = acc_q[idx_q];
      cur_bit = note_q[idx_q];
      new_bit = cur_bit;
      on_n    = '0;
      off_n   = '0;
      // On-test first so overlapping thresholds favour switching on.
      if (p > i_thr_on) begin
         if (!cur_bit) begin
            if (on_cnt_q[idx_q] + CNT_W'(1) == HOLD_CNT) new_bit = 1'b1;
            else on_n = on_cnt_q[idx_q] + CNT_W'(1);
         end
      end else if (p < i_thr_off) begin
         if (cur_bit) begin
            if (off_cnt_q[idx_q] + CNT_W'(1) == HOLD_CNT) new_bit = 1'b0;
            else off_n = off_cnt_q[idx_q] + CNT_W'(1);
         end
      end
      note_final        = note_work_q;
      note_final[idx_q] = new_bit;
      take              = (idx_q == '0) || (p > max_q);
      max_nxt           = take ? p : max_q;
      band_nxt          = take ? idx_q : max_band_q;
      last              = (idx_q == LAST_BAND);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (frame_end) state_d = ST_EVAL;
                   else if (accept) state_d = ST_ACCUM;
         ST_ACCUM: if (frame_end) state_d = ST_EVAL;
         ST_EVAL:  if (last) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         note_work_q <= '0;
         note_q      <= '0;
         idx_q       <= '0;
         max_q       <= '0;
         max_band_q  <= '0;
         power_q     <= '0;
         peak_q      <= '0;
         for (int unsigned k = 0; k < NUM_BANDS; k++) begin
            acc_q[k]     <= '0;
            on_cnt_q[k]  <= '0;
            off_cnt_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         for (int unsigned k = 0; k < NUM_BANDS; k++) acc_q[k] <= acc_d[k];
         if (state_q == ST_EVAL) begin
            idx_q            <= idx_q + BAND_W'(1);
            on_cnt_q[idx_q]  <= on_n;
            off_cnt_q[idx_q] <= off_n;
            note_work_q      <= note_final;
            max_q            <= max_nxt;
            max_band_q       <= band_nxt;
            // Outputs are loaded on the last evaluation edge so they appear with the DONE pulse.
            if (last) begin
               note_q  <= note_final;
               power_q <= max_nxt;
               peak_q  <= band_nxt;
            end
         end else begin
            idx_q <= '0;
         end
      end
   end

   assign o_note       = note_q;
   assign o_power      = power_q;
   assign o_peak_band  = peak_q;
   assign o_frame_done = (state_q == ST_DONE);
   assign o_busy       = (state_q == ST_EVAL) || (state_q == ST_DONE);

endmodule

// File: tb/tb_fft_band_detect.sv
// Scoreboarded bench for fft_band_detect: a behavioural band/hysteresis model queues the expected
// outputs per frame, a monitor checks them on each frame_done pulse, scenario tasks add direct checks.
module tb_fft_band_detect;

   localparam int FFT_LEN     = 1024;
   localparam int BIN_W       = 10;
   localparam int PWR_W       = 32;
   localparam int NUM_BANDS   = 25;
   localparam int FIRST_BIN   = 8;
   localparam int BAND_WIDTH  = 4;
   localparam int HOLD_FRAMES = 2;
   localparam int ACC_W       = 34;
   localparam int BAND_W      = 5;
   localparam int LATENCY     = NUM_BANDS + 1;
   localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 valid, sop;
   logic [BIN_W-1:0]     bin;
   logic [PWR_W-1:0]     power;
   logic [ACC_W-1:0]     thr_on, thr_off;
   logic [NUM_BANDS-1:0] o_note;
   logic [ACC_W-1:0]     o_power;
   logic [BAND_W-1:0]    o_peak_band;
   logic                 o_frame_done, o_busy;

   always #5 clk = ~clk;

   fft_band_detect #(
      .FFT_LEN     (FFT_LEN),
      .BIN_W       (BIN_W),
      .PWR_W       (PWR_W),
      .NUM_BANDS   (NUM_BANDS),
      .FIRST_BIN   (FIRST_BIN),
      .BAND_WIDTH  (BAND_WIDTH),
      .HOLD_FRAMES (HOLD_FRAMES)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_valid      (valid),
      .i_sop        (sop),
      .i_bin        (bin),
      .i_power      (power),
      .i_thr_on     (thr_on),
      .i_thr_off    (thr_off),
      .o_note       (o_note),
      .o_power      (o_power),
      .o_peak_band  (o_peak_band),
      .o_frame_done (o_frame_done),
      .o_busy       (o_busy)
   );

   typedef struct packed {
      logic [NUM_BANDS-1:0] note;
      logic [ACC_W-1:0]     pwr;
      logic [BAND_W-1:0]    band;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   done_count = 0;

   longint unsigned      m_acc [NUM_BANDS];
   int                   m_on [NUM_BANDS];
   int                   m_off [NUM_BANDS];
   logic [NUM_BANDS-1:0] m_note;
   bit                   m_active;

   logic [PWR_W-1:0] fpwr [FFT_LEN];
   int               dup_bin = -1;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && o_frame_done === 1'b1) begin
         done_count++;
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_done_unexpected: got pulse, required none");
         end else begin
            e = sb.pop_front();
            vectors += 3;
            if (o_note !== e.note) begin
               miscompares++;
               $display("FAIL sb_note: got %h, required %h", o_note, e.note);
            end
            if (o_power !== e.pwr) begin
               miscompares++;
               $display("FAIL sb_power: got %0d, required %0d", o_power, e.pwr);
            end
            if (o_peak_band !== e.band) begin
               miscompares++;
               $display("FAIL sb_peak_band: got %0d, required %0d", o_peak_band, e.band);
            end
         end
      end
   end

   task automatic model_reset();
      m_note   = '0;
      m_active = 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) begin
         m_acc[k] = 0;
         m_on[k]  = 0;
         m_off[k] = 0;
      end
   endtask

   task automatic model_eval();
      exp_t            e;
      longint unsigned best;
      int              best_k;
      best   = 0;
      best_k = 0;
      for (int k = 0; k < NUM_BANDS; k++) begin
         if (m_acc[k] > longint'(thr_on)) begin
            m_off[k] = 0;
            if (m_note[k] == 1'b0) begin
               m_on[k]++;
               if (m_on[k] >= HOLD_FRAMES) begin
                  m_note[k] = 1'b1;
                  m_on[k]   = 0;
               end
            end else m_on[k] = 0;
         end else if (m_acc[k] < longint'(thr_off)) begin
            m_on[k] = 0;
            if (m_note[k] == 1'b1) begin
               m_off[k]++;
               if (m_off[k] >= HOLD_FRAMES) begin
                  m_note[k] = 1'b0;
                  m_off[k]  = 0;
               end
            end else m_off[k] = 0;
         end else begin
            m_on[k]  = 0;
            m_off[k] = 0;
         end
         if (k == 0 || m_acc[k] > best) begin
            best   = m_acc[k];
            best_k = k;
         end
      end
      e.note = m_note;
      e.pwr  = ACC_W'(best);
      e.band = BAND_W'(best_k);
      sb.push_back(e);
      for (int k = 0; k < NUM_BANDS; k++) m_acc[k] = 0;
   endtask

   task automatic model_sample(input int b, input longint unsigned p, input bit s);
      int k;
      if (s) begin
         for (int j = 0; j < NUM_BANDS; j++) m_acc[j] = 0;
         m_active = 1'b1;
      end
      if (m_active) begin
         if (b >= FIRST_BIN && b < FIRST_BIN + NUM_BANDS * BAND_WIDTH) begin
            k = (b - FIRST_BIN) / BAND_WIDTH;
            m_acc[k] = m_acc[k] + p;
            if (m_acc[k] > ACC_MAX) m_acc[k] = ACC_MAX;
         end
         if (b == FFT_LEN - 1) begin
            model_eval();
            m_active = 1'b0;
         end
      end
   endtask

   task automatic drive(input int b, input logic [PWR_W-1:0] p, input bit s, input bit use_model);
      valid = 1'b1;
      bin   = BIN_W'(b);
      power = p;
      sop   = s;
      if (use_model) model_sample(b, longint'(p), s);
      @(posedge clk);
      #1;
      valid = 1'b0;
      sop   = 1'b0;
   endtask

   // Returns cycles from the frame-end edge to the pulse; 0 on timeout. Leaves the bench in IDLE.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (o_frame_done === 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL frame_done_timeout: got no pulse in 60 cycles, required one");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_frame();
      for (int b = 0; b < FFT_LEN; b++) fpwr[b] = '0;
      dup_bin = -1;
   endtask

   task automatic send_frame(output int lat);
      for (int b = 0; b < FFT_LEN; b++) begin
         drive(b, fpwr[b], b == 0, 1'b1);
         if (b == dup_bin) drive(b, fpwr[b], 1'b0, 1'b1);
      end
      wait_done(lat);
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      valid   = 1'b0;
      sop     = 1'b0;
      bin     = '0;
      power   = '0;
      thr_on  = 34'd2000;
      thr_off = 34'd500;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      vectors += 5;
      if (o_note !== '0)        begin miscompares++; $display("FAIL reset_note: got %h, required 0", o_note); end
      if (o_power !== '0)       begin miscompares++; $display("FAIL reset_power: got %0d, required 0", o_power); end
      if (o_peak_band !== '0)   begin miscompares++; $display("FAIL reset_peak: got %0d, required 0", o_peak_band); end
      if (o_frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, required 0", o_frame_done); end
      if (o_busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
   endtask

   task automatic test_single_band();
      int lat;
      clear_frame();
      for (int b = 12; b <= 15; b++) fpwr[b] = 32'd1000;
      send_frame(lat);
      vectors += 4;
      if (lat !== LATENCY)        begin miscompares++; $display("FAIL latency: got %0d, required %0d", lat, LATENCY); end
      if (o_note !== '0)          begin miscompares++; $display("FAIL band1_first_note: got %h, required 0", o_note); end
      if (o_power !== 34'd4000)   begin miscompares++; $display("FAIL band1_power: got %0d, required 4000", o_power); end
      if (o_peak_band !== 5'd1)   begin miscompares++; $display("FAIL band1_peak: got %0d, required 1", o_peak_band); end
      send_frame(lat);
      vectors++;
      if (o_note !== 25'h2) begin miscompares++; $display("FAIL band1_second_note: got %h, required 2", o_note); end
   endtask

   task automatic test_hysteresis();
      int lat;
      clear_frame();
      send_frame(lat);
      vectors++;
      if (o_note !== 25'h2) begin miscompares++; $display("FAIL off_hold: got %h, required 2", o_note); end
      send_frame(lat);
      vectors++;
      if (o_note !== '0) begin miscompares++; $display("FAIL off_clear: got %h, required 0", o_note); end
      // Alternate above-on and between-thresholds frames: the on count never reaches two.
      for (int i = 0; i < 4; i++) begin
         clear_frame();
         if (i % 2 == 0) for (int b = 12; b <= 15; b++) fpwr[b] = 32'd1000;
         else fpwr[12] = 32'd1000;
         send_frame(lat);
         vectors++;
         if (o_note[1] !== 1'b0) begin miscompares++; $display("FAIL alt_frame%0d_note1: got %b, required 0", i, o_note[1]); end
      end
   endtask

   task automatic test_saturation();
      int lat;
      clear_frame();
      for (int b = 8; b <= 11; b++) fpwr[b] = 32'hFFFF_FFFF;
      send_frame(lat);
      vectors += 2;
      if (o_power !== 34'h3_FFFF_FFFC) begin miscompares++; $display("FAIL full_band_sum: got %h, required 3fffffffc", o_power); end
      if (o_peak_band !== 5'd0)        begin miscompares++; $display("FAIL full_band_peak: got %0d, required 0", o_peak_band); end
      dup_bin = 8;
      send_frame(lat);
      vectors++;
      if (o_power !== 34'h3_FFFF_FFFF) begin miscompares++; $display("FAIL saturate: got %h, required 3ffffffff", o_power); end
   endtask

   task automatic test_mid_sop();
      int lat, d0;
      d0 = done_count;
      for (int b = 0; b < 500; b++) drive(b, (b >= 20 && b <= 23) ? 32'd50000 : 32'd0, b == 0, 1'b1);
      drive(500, 32'd0, 1'b1, 1'b1);
      for (int b = 501; b < FFT_LEN; b++) drive(b, 32'd0, 1'b0, 1'b1);
      wait_done(lat);
      repeat (30) @(posedge clk);
      #1;
      vectors += 3;
      if (lat !== LATENCY)         begin miscompares++; $display("FAIL restart_latency: got %0d, required %0d", lat, LATENCY); end
      if (o_power !== '0)          begin miscompares++; $display("FAIL restart_power: got %0d, required 0", o_power); end
      if (done_count - d0 !== 1)   begin miscompares++; $display("FAIL restart_done_count: got %0d, required 1", done_count - d0); end
   endtask

   task automatic test_peak_tie_and_busy();
      int lat;
      clear_frame();
      for (int b = 24; b <= 27; b++) fpwr[b] = 32'd750;
      for (int b = 44; b <= 47; b++) fpwr[b] = 32'd750;
      for (int b = 0; b < FFT_LEN; b++) drive(b, fpwr[b], b == 0, 1'b1);
      // Busy-window samples (sop included) must be dropped.
      for (int i = 0; i < LATENCY; i++) begin
         vectors++;
         if (o_busy !== 1'b1) begin miscompares++; $display("FAIL busy_cycle%0d: got %b, required 1", i, o_busy); end
         drive(16 + (i % 4), 32'd99999, 1'b1, 1'b0);
      end
      vectors += 3;
      if (o_busy !== 1'b0)       begin miscompares++; $display("FAIL busy_release: got %b, required 0", o_busy); end
      if (o_peak_band !== 5'd4)  begin miscompares++; $display("FAIL tie_peak: got %0d, required 4", o_peak_band); end
      if (o_power !== 34'd3000)  begin miscompares++; $display("FAIL tie_power: got %0d, required 3000", o_power); end
      clear_frame();
      for (int b = 28; b <= 31; b++) fpwr[b] = 32'd500;
      send_frame(lat);
      vectors += 2;
      if (o_peak_band !== 5'd5)  begin miscompares++; $display("FAIL post_busy_peak: got %0d, required 5", o_peak_band); end
      if (o_power !== 34'd2000)  begin miscompares++; $display("FAIL post_busy_power: got %0d, required 2000", o_power); end
   endtask

   task automatic test_reset_in_eval();
      int lat, d0;
      clear_frame();
      for (int b = 12; b <= 15; b++) fpwr[b] = 32'd1000;
      for (int b = 0; b < FFT_LEN; b++) drive(b, fpwr[b], b == 0, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      vectors++;
      if (o_busy !== 1'b1) begin miscompares++; $display("FAIL eval_busy: got %b, required 1", o_busy); end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      model_reset();
      vectors += 5;
      if (o_note !== '0)         begin miscompares++; $display("FAIL eval_rst_note: got %h, required 0", o_note); end
      if (o_power !== '0)        begin miscompares++; $display("FAIL eval_rst_power: got %0d, required 0", o_power); end
      if (o_peak_band !== '0)    begin miscompares++; $display("FAIL eval_rst_peak: got %0d, required 0", o_peak_band); end
      if (o_busy !== 1'b0)       begin miscompares++; $display("FAIL eval_rst_busy: got %b, required 0", o_busy); end
      if (o_frame_done !== 1'b0) begin miscompares++; $display("FAIL eval_rst_done: got %b, required 0", o_frame_done); end
      d0 = done_count;
      repeat (40) @(posedge clk);
      #1;
      vectors++;
      if (done_count !== d0) begin miscompares++; $display("FAIL eval_rst_no_pulse: got %0d pulses, required 0", done_count - d0); end
      send_frame(lat);
      vectors += 2;
      if (lat !== LATENCY)       begin miscompares++; $display("FAIL post_rst_latency: got %0d, required %0d", lat, LATENCY); end
      if (o_power !== 34'd4000)  begin miscompares++; $display("FAIL post_rst_power: got %0d, required 4000", o_power); end
   endtask

   initial begin
      test_reset();
      test_single_band();
      test_hysteresis();
      test_saturation();
      test_mid_sop();
      test_peak_tie_and_busy();
      test_reset_in_eval();
      repeat (2) @(posedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fft_band_detect.md
Name: fft_band_detect

Overview:
- Parametrised successor to the single-configuration note detector behind the FFT in the listening path.
- Consumes the streamed per-bin power (real²+imag²) from the FFT output, indexed by bin counter. Accumulates power into NUM_BANDS contiguous bin bands per frame.
- Evaluates each band against on/off hysteresis thresholds with multi-frame debounce. Drives a note/band bitmap plus peak band and peak power to the note bus.

Parameters:
FFT_LEN, 1024, bins per frame; the frame ends on bin FFT_LEN-1
BIN_W, 10, width of bin index (clog2(FFT_LEN))
PWR_W, 32, width of per-bin power input
NUM_BANDS, 25, number of bands (one output bit each)
FIRST_BIN, 8, first bin of band 0
BAND_WIDTH, 4, bins per band; must be a power of two
HOLD_FRAMES, 2, consecutive qualifying frames needed to set or clear a band bit (>=1)
ACC_W (localparam), PWR_W+clog2(BAND_WIDTH), band accumulator width

Ports:
i_clk  in  1  clock (FFT/down-sampled domain)
i_rst_n  in  1  synchronous active-low reset
i_valid  in  1  bin sample valid
i_sop  in  1  start of frame, qualified by i_valid
i_bin  in  BIN_W  bin index of current sample
i_power  in  PWR_W  unsigned bin power
i_thr_on  in  ACC_W  band power strictly above this qualifies "on"
i_thr_off  in  ACC_W  band power strictly below this qualifies "off"
o_note  out  NUM_BANDS  debounced band-active bitmap
o_power  out  ACC_W  largest band power of the last evaluated frame
o_peak_band  out  clog2(NUM_BANDS)  index of that band
o_frame_done  out  1  one-cycle pulse when outputs update
o_busy  out  1  high in EVAL/DONE; inputs are ignored while high

Behaviour:
- Reset (sync, i_rst_n=0 at a rising edge): state IDLE, all accumulators and debounce counters cleared. o_note=0, o_power=0, o_peak_band=0, o_frame_done=0, o_busy=0. Applies mid-ACCUM or mid-EVAL; the partial frame is discarded.
- States: IDLE, ACCUM, EVAL, DONE.
- IDLE: waits for i_valid&i_sop. That sample is accumulated and the state moves to ACCUM. Non-sop samples are ignored.
- ACCUM: every i_valid sample is accumulated.
  - Band index = (i_bin-FIRST_BIN)>>log2(BAND_WIDTH).
  - Bins < FIRST_BIN or >= FIRST_BIN+NUM_BANDS*BAND_WIDTH are dropped.
  - Accumulation saturates at 2^ACC_W-1.
- i_valid&i_sop in ACCUM: all accumulators are cleared, the sop sample is taken as the first sample, and ACCUM is restarted. No frame_done is issued for the abandoned frame.
- Frame end: an accepted sample with i_bin==FFT_LEN-1 (sample still accumulated if in range). Call this cycle T; the next state is EVAL.
- EVAL: one band per cycle, band 0 in cycle T+1 through band NUM_BANDS-1 in cycle T+NUM_BANDS.
- Per band k, with P = its accumulated power:
  - P > i_thr_on: the off-counter is cleared. If o_note[k]=0, the on-counter is incremented; when it reaches HOLD_FRAMES, o_note[k] is set to 1 (applied at DONE) and the counter is cleared.
  - P < i_thr_off: mirror rule using the off-counter, clearing o_note[k].
  - Otherwise (between thresholds, or already in target state): both counters are cleared and the bit holds.
  - If i_thr_off > i_thr_on, the on-test has priority.
- Peak tracking during EVAL: a running max with a strict > compare, so ties keep the lowest band index.
- DONE (cycle T+NUM_BANDS+1):
  - o_note, o_power and o_peak_band are updated, registered together, and o_frame_done=1.
  - Accumulators are cleared; the next state is IDLE.
- Outputs hold between DONE pulses.
- o_busy=1 in EVAL and DONE. Any i_valid (including sop) during these cycles is dropped; the next frame needs a fresh sop in IDLE.
- Latency: frame-end sample to o_frame_done = NUM_BANDS+1 cycles.
- Bins within a frame may arrive in any order or with gaps; only bin FFT_LEN-1 ends the frame.

Test Plan:
1. Reset, then one frame (sop at bin 0, bins 0..1023, valid every cycle). Power 1000 on bins 12..15 (band 1), 0 elsewhere; thr_on=2000, thr_off=500.
   - Frame 1: o_frame_done 26 cycles after bin 1023, o_note=0, o_power=4000, o_peak_band=1.
   - Same frame again: o_note=25'h2.
2. After scenario 1, two frames of all-zero power -> o_note[1] holds after the first frame and clears after the second. Drive a band power of 1000 (between thresholds) on alternate frames -> the counters clear and the bit never changes.
3. Bin 8 power 2^32-1 on all four bins of band 0 with ACC_W=34 -> the sum is 4·(2^32-1) with no wrap. Force saturation by feeding bin 8 twice -> o_power stays at 2^34-1.
4. Mid-frame sop at bin 500 after large band-3 power, then a clean frame with zeros -> o_power=0. Only one o_frame_done is issued.
5. Equal power 3000 in bands 4 and 9 -> o_peak_band=4. Samples with valid=1 during o_busy are not counted: the next frame's sums show only its own data.
6. Assert i_rst_n=0 for one cycle during EVAL -> next cycle all outputs are 0, o_busy=0, and no o_frame_done pulse.
